// File: rtl/md_ctrl_if.sv
// HI/LO multiply/divide unit connection between the E stage, the hazard unit and md_ctrl.
interface md_ctrl_if;
    logic        Req;
    logic        startE;
    logic [2:0]  mdopE;
    logic [31:0] rsE;
    logic [31:0] rtE;
    logic        md_useD;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output Req, startE, mdopE, rsE, rtE, md_useD,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  Req, startE, mdopE, rsE, rtE, md_useD,
        output busy, stall_md, hi, lo
    );
endinterface

// File: rtl/md_ctrl.sv
// HI/LO multiply/divide sequencer: captures the result at issue, holds busy for a fixed
// latency, then commits into HI/LO. Requests a D/E stall while a HI/LO user waits.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    md_ctrl_if.slave   md
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // Returns {hi, lo} of a 32x32 product, sign-extending operands when sgn is set.
    function automatic logic [63:0] f_mult(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{a[31] & sgn}}, a};
        eb = {{32{b[31] & sgn}}, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}; signed mode works on magnitudes so MIN/-1 wraps cleanly.
    function automatic logic [63:0] f_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        ua    = neg_a ? (32'd0 - a) : a;
        ub    = neg_b ? (32'd0 - b) : b;
        q     = (ub == 32'd0) ? 32'd0 : (ua / ub);
        r     = (ub == 32'd0) ? 32'd0 : (ua % ub);
        if (neg_a ^ neg_b) q = 32'd0 - q;
        if (neg_a)         r = 32'd0 - r;
        return {r, q};
    endfunction

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic          pend_vld_q, pend_vld_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          busy_s;
    logic          req_s;
    logic          md_op_s;
    logic          issue_s;

    assign busy_s  = (state_q == ST_RUN);
    assign req_s   = (md.Req === 1'b1);
    assign md_op_s = (md.mdopE >= OP_MULT) && (md.mdopE <= OP_DIVU);
    assign issue_s = md.startE && (md.mdopE >= OP_MULT) && (md.mdopE <= OP_MTLO)
                     && !busy_s && !req_s;

    assign md.busy     = busy_s;
    assign md.stall_md = md.md_useD & (busy_s | (md.startE & md_op_s & ~req_s));
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

    // Next-state: issue capture in IDLE, countdown and commit in RUN.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pend_hi_d  = pend_hi_q;
        pend_lo_d  = pend_lo_q;
        pend_vld_d = pend_vld_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    case (md.mdopE)
                        OP_MULT, OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = f_mult(md.rsE, md.rtE, md.mdopE == OP_MULT);
                            pend_vld_d = 1'b1;
                            count_d    = CW'(MULT_CYCLES);
                            state_d    = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            {pend_hi_d, pend_lo_d} = f_div(md.rsE, md.rtE, md.mdopE == OP_DIV);
                            pend_vld_d = (md.rtE != 32'd0);
                            count_d    = CW'(DIV_CYCLES);
                            state_d    = ST_RUN;
                        end
                        OP_MTHI: hi_d = md.rsE;
                        OP_MTLO: lo_d = md.rsE;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d    = ST_IDLE;
                    pend_vld_d = 1'b0;
                    if (pend_vld_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end else begin
                        hi_d = hi_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // State and HI/LO registers; reset aborts any running operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            pend_hi_q  <= 32'd0;
            pend_lo_q  <= 32'd0;
            pend_vld_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pend_hi_q  <= pend_hi_d;
            pend_lo_q  <= pend_lo_d;
            pend_vld_q <= pend_vld_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end
endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios plus randomized ops against a 64-bit model.
module tb_md_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_ctrl_if mif();

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        mif.Req = 1'b0; mif.startE = 1'b0; mif.mdopE = 3'd0;
        mif.rsE = 32'd0; mif.rtE = 32'd0; mif.md_useD = 1'b0;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic req, input logic use_d);
        mif.startE = 1'b1; mif.mdopE = op; mif.rsE = a; mif.rtE = b;
        mif.Req = req; mif.md_useD = use_d;
    endtask

    // Counts busy cycles and cycles with stall_md high until busy drops (bounded).
    task automatic wait_idle(output int cyc, output int st);
        cyc = 0; st = 0;
        while (mif.busy === 1'b1 && cyc < 100) begin
            if (mif.stall_md === 1'b1) st++;
            cyc++;
            tick();
        end
    endtask

    function automatic int lat(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return 5;
            3'd3, 3'd4: return 10;
            default:    return 0;
        endcase
    endfunction

    // Architectural result of an accepted op, using 64-bit integer arithmetic.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        logic [63:0]     v;
        sa = $signed(a); sb = $signed(b); ua = a; ub = b;
        case (op)
            3'd1: begin sp = sa * sb; v = sp; m_hi = v[63:32]; m_lo = v[31:0]; end
            3'd2: begin up = ua * ub; v = up; m_hi = v[63:32]; m_lo = v[31:0]; end
            3'd3: if (b != 32'd0) begin
                sq = sa / sb; sr = sa % sb;
                v = sq; m_lo = v[31:0];
                v = sr; m_hi = v[31:0];
            end
            3'd4: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic test_reset;
        int cyc, st;
        idle_inputs();
        reset = 1'b0;
        #12;
        n_tests++;
        if (mif.busy !== 1'b0 || mif.stall_md !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state busy=%b stall=%b hi=%h lo=%h, required 0/0/0/0",
                     mif.busy, mif.stall_md, mif.hi, mif.lo);
        end
        reset = 1'b1;
        tick();
        drive(3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        tick();
        idle_inputs();
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        n_tests++;
        if (mif.busy !== 1'b0 || mif.hi !== 32'd0 || mif.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_div busy=%b hi=%h lo=%h, required 0/0/0", mif.busy, mif.hi, mif.lo);
        end
        #1 reset = 1'b1;
        drive(3'd1, 32'd9, 32'd9, 1'b0, 1'b0);
        tick();
        idle_inputs();
        n_tests++;
        if (mif.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_after_reset busy=%b, required 1", mif.busy);
        end
        wait_idle(cyc, st);
        model_apply(3'd1, 32'd9, 32'd9);
        n_tests++;
        if (cyc != 5 || mif.hi !== m_hi || mif.lo !== m_lo) begin
            n_fail++;
            $display("FAIL reset_then_mult cycles=%0d hi=%h lo=%h, required 5 %h %h", cyc, mif.hi, mif.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_mult;
        int cyc, st;
        logic [31:0] old_hi;
        for (int k = 1; k <= 2; k++) begin
            old_hi = m_hi;
            drive(3'(k), 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
            tick();
            idle_inputs();
            n_tests++;
            if (mif.hi !== old_hi) begin
                n_fail++;
                $display("FAIL mult_no_bypass op=%0d hi=%h, required %h", k, mif.hi, old_hi);
            end
            wait_idle(cyc, st);
            model_apply(3'(k), 32'hFFFF_FFFE, 32'd3);
            n_tests++;
            if (cyc != 5 || mif.hi !== m_hi || mif.lo !== m_lo) begin
                n_fail++;
                $display("FAIL mult op=%0d cycles=%0d hi=%h lo=%h, required 5 %h %h", k, cyc, mif.hi, mif.lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_div;
        int cyc, st;
        logic [2:0]  ops [3] = '{3'd3, 3'd4, 3'd3};
        logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [31:0] bs  [3] = '{32'd2, 32'd0, 32'hFFFF_FFFF};
        for (int k = 0; k < 3; k++) begin
            drive(ops[k], as[k], bs[k], 1'b0, 1'b0);
            tick();
            idle_inputs();
            wait_idle(cyc, st);
            model_apply(ops[k], as[k], bs[k]);
            n_tests++;
            if (cyc != 10 || mif.hi !== m_hi || mif.lo !== m_lo) begin
                n_fail++;
                $display("FAIL div case=%0d cycles=%0d hi=%h lo=%h, required 10 %h %h", k, cyc, mif.hi, mif.lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_req;
        int cyc, st;
        drive(3'd3, 32'd50, 32'd3, 1'b1, 1'b1);
        #1;
        n_tests++;
        if (mif.stall_md !== 1'b0) begin
            n_fail++;
            $display("FAIL req_stall stall=%b, required 0", mif.stall_md);
        end
        tick();
        idle_inputs();
        n_tests++;
        if (mif.busy !== 1'b0 || mif.hi !== m_hi || mif.lo !== m_lo) begin
            n_fail++;
            $display("FAIL req_cancel busy=%b hi=%h lo=%h, required 0 %h %h", mif.busy, mif.hi, mif.lo, m_hi, m_lo);
        end
        drive(3'd6, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        tick();
        idle_inputs();
        n_tests++;
        if (mif.lo !== m_lo) begin
            n_fail++;
            $display("FAIL req_cancel_mtlo lo=%h, required %h", mif.lo, m_lo);
        end
        drive(3'd3, 32'd1000, 32'd7, 1'b0, 1'b0);
        tick();
        idle_inputs();
        tick();
        mif.Req = 1'b1;
        tick();
        mif.Req = 1'b0;
        wait_idle(cyc, st);
        model_apply(3'd3, 32'd1000, 32'd7);
        n_tests++;
        if (cyc + 2 != 10 || mif.hi !== m_hi || mif.lo !== m_lo) begin
            n_fail++;
            $display("FAIL req_during_run cycles=%0d hi=%h lo=%h, required 10 %h %h", cyc + 2, mif.hi, mif.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_stall;
        int cyc, st;
        for (int u = 1; u >= 0; u--) begin
            drive(3'd1, 32'd12345, 32'd678, 1'b0, u[0]);
            #1;
            n_tests++;
            if (mif.stall_md !== u[0]) begin
                n_fail++;
                $display("FAIL stall_issue use=%0d stall=%b, required %b", u, mif.stall_md, u[0]);
            end
            tick();
            mif.startE = 1'b0;
            wait_idle(cyc, st);
            model_apply(3'd1, 32'd12345, 32'd678);
            n_tests++;
            if (st != 5 * u || mif.stall_md !== 1'b0 || mif.lo !== m_lo) begin
                n_fail++;
                $display("FAIL stall_busy use=%0d stall_cycles=%0d stall_after=%b lo=%h, required %0d 0 %h",
                         u, st, mif.stall_md, mif.lo, 5 * u, m_lo);
            end
            idle_inputs();
        end
    endtask

    task automatic test_back_to_back;
        int cyc, st;
        drive(3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        tick();
        model_apply(3'd5, 32'h1234_5678, 32'd0);
        n_tests++;
        if (mif.hi !== m_hi || mif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi hi=%h busy=%b, required %h 0", mif.hi, mif.busy, m_hi);
        end
        drive(3'd6, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
        tick();
        model_apply(3'd6, 32'h9ABC_DEF0, 32'd0);
        n_tests++;
        if (mif.lo !== m_lo || mif.hi !== m_hi || mif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo hi=%h lo=%h busy=%b, required %h %h 0", mif.hi, mif.lo, mif.busy, m_hi, m_lo);
        end
        drive(3'd1, 32'd77, 32'hFFFF_FFF0, 1'b0, 1'b0);
        tick();
        drive(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
        wait_idle(cyc, st);
        model_apply(3'd1, 32'd77, 32'hFFFF_FFF0);
        n_tests++;
        if (cyc != 5 || mif.hi !== m_hi || mif.lo !== m_lo) begin
            n_fail++;
            $display("FAIL mthi_held cycles=%0d hi=%h lo=%h, required 5 %h %h", cyc, mif.hi, mif.lo, m_hi, m_lo);
        end
        tick();
        idle_inputs();
        model_apply(3'd5, 32'hCAFE_F00D, 32'd0);
        n_tests++;
        if (mif.hi !== m_hi) begin
            n_fail++;
            $display("FAIL mthi_after_busy hi=%h, required %h", mif.hi, m_hi);
        end
    endtask

    task automatic test_random;
        int cyc, st, exp_lat;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        req, use_d, acc, exp_stall;
        for (int k = 0; k < 40; k++) begin
            op    = 3'($urandom_range(0, 7));
            a     = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            req   = ($urandom_range(0, 5) == 0);
            use_d = 1'($urandom_range(0, 1));
            acc   = (op >= 3'd1) && (op <= 3'd6) && !req;
            exp_stall = use_d && (op >= 3'd1) && (op <= 3'd4) && !req;
            exp_lat = acc ? lat(op) : 0;
            drive(op, a, b, req, use_d);
            #1;
            n_tests++;
            if (mif.stall_md !== exp_stall) begin
                n_fail++;
                $display("FAIL rand_stall k=%0d op=%0d stall=%b, required %b", k, op, mif.stall_md, exp_stall);
            end
            tick();
            idle_inputs();
            wait_idle(cyc, st);
            if (acc) model_apply(op, a, b);
            n_tests++;
            if (cyc != exp_lat || mif.hi !== m_hi || mif.lo !== m_lo) begin
                n_fail++;
                $display("FAIL rand_op k=%0d op=%0d a=%h b=%h req=%b cycles=%0d hi=%h lo=%h, required %0d %h %h",
                         k, op, a, b, req, cyc, mif.hi, mif.lo, exp_lat, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_req();
        test_stall();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Sequencer for the shared HI/LO multiply/divide resource that feeds HILO_res into the E→M pipeline register.
- Accepts a mult/div/mthi/mtlo issue from the E stage and runs a fixed-latency busy countdown.
- Commits results into HI/LO and drives the stall request that the hazard unit uses to freeze D/E when a HI/LO user is behind a busy unit.
- Honours the exception request Req: an op issuing in the same cycle as Req is cancelled; an op already running completes.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Req  input  1  exception/interrupt request; an issue is cancelled only when Req === 1'b1
startE  input  1  E-stage instruction is an HI/LO op, qualified by mdopE
mdopE  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
rsE  input  32  forwarded rs operand
rtE  input  32  forwarded rt operand
md_useD  input  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo
busy  output  1  multi-cycle op in progress
stall_md  output  1  stall request to hazard unit
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset==0, async): state=IDLE, count=0, hi=0, lo=0, busy=0, stall_md=0; pending results cleared. A reset mid-operation aborts it; HI/LO stay 0.
- States: IDLE, RUN.
- Valid issue = startE & (mdopE in 1..6) & !busy & !(Req===1'b1).
- Mult/div issue (ops 1-4) in IDLE:
  - Compute the 64-bit result from rsE/rtE at the issue edge into pend_hi/pend_lo.
  - count ← MULT_CYCLES or DIV_CYCLES; state → RUN; busy=1 from the next cycle.
- RUN:
  - count decrements every edge.
  - On the edge where count==1: hi←pend_hi, lo←pend_lo, state→IDLE, busy→0.
  - busy is high for exactly N cycles; the first cycle after busy falls sees the new HI/LO.
- MTHI/MTLO issue: hi←rsE or lo←rsE at the issue edge; no busy.
- startE while busy: ignored (the hazard unit keeps the op held in E via stall_md).
- Req during RUN: no effect; the op completes and commits.
- Req===1'b1 on an issue cycle: no state change, HI/LO untouched. Req==X/Z is treated as 0.
- Arithmetic:
  - MULT: signed 32×32→64, {hi,lo}.
  - MULTU: unsigned 32×32→64.
  - DIV: lo = quotient truncated toward zero, hi = remainder with the dividend's sign.
  - DIVU: unsigned quotient/remainder.
  - Divisor 0: hi, lo unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- stall_md (combinational) = md_useD & (busy | (startE & mdopE in 1..4 & !(Req===1'b1))).
- Simultaneous commit edge and new issue: not possible because busy blocks the issue. The first issue is accepted on the cycle busy reads 0.
- hi/lo are register outputs; no combinational bypass from pend.

Test Plan:
1. Reset: drive reset=0 mid-DIV (count=6), then release → hi=lo=0, busy=0 immediately, and a new issue is accepted on the first cycle after release.
2. MULT rsE=0xFFFFFFFE, rtE=3, MULT_CYCLES=5 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
3. DIV rsE=-7 (0xFFFFFFF9), rtE=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 → hi/lo unchanged.
4. Issue DIV with Req=1 in the same cycle → busy stays 0, hi/lo unchanged; DIV issued one cycle earlier with Req in its 2nd busy cycle → completes, commits at cycle 10.
5. md_useD=1 (mflo) behind MULT → stall_md=1 on the issue cycle plus all 5 busy cycles, 0 afterwards; mflo reads the new lo. md_useD=0 → stall_md=0 throughout.
6. MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back → hi/lo update on successive edges, busy=0; startE=1 with MTHI during a busy MULT → ignored until busy falls.
